// File: rtl/fpu_cvt_pkg.sv
// Shared encodings and constants for the FP64<->FP32 convert scheduler.
package fpu_cvt_pkg;
  localparam logic        CVT_D2S       = 1'b0;
  localparam logic        CVT_S2D       = 1'b1;
  localparam logic [11:0] EXP_BIAS_DIFF = 12'd896;
  localparam logic [7:0]  F32_INF_EXP   = 8'hFF;
  localparam logic [10:0] F64_INF_EXP   = 11'h7FF;

  typedef struct packed {
    logic [63:0] data;
    logic        ovf;
    logic        unf;
  } cvt_res_t;
endpackage

// File: rtl/fpu_cvt_core.sv
// Combinational FP64<->FP32 converter; no denormal, NaN or rounding handling.
module fpu_cvt_core
  import fpu_cvt_pkg::*;
(
  input  logic        op,
  input  logic [63:0] src,
  output cvt_res_t    res
);
  logic [11:0] eb;
  logic [10:0] e64;

  always_comb begin
    res = '0;
    eb  = {1'b0, src[62:52]} - EXP_BIAS_DIFF;
    e64 = {3'b000, src[30:23]} + EXP_BIAS_DIFF[10:0];
    if (op == CVT_D2S) begin
      // eb negative -> underflow; eb above 8 bits -> overflow (NaN lands here too)
      if (eb[11]) begin
        res.unf = 1'b1;
      end else if (eb[11:8] == 4'h0) begin
        res.data[31:0] = {src[63], eb[7:0], src[51:29]};
      end else begin
        res.data[31:0] = {src[63], F32_INF_EXP, 23'h0};
        res.ovf        = 1'b1;
      end
    end else begin
      if (src[30:23] == 8'h00)
        res.data = {src[31], 63'h0};
      else if (src[30:23] == F32_INF_EXP)
        res.data = {src[31], F64_INF_EXP, src[22:0], 29'h0};
      else
        res.data = {src[31], e64, src[22:0], 29'h0};
    end
  end
endmodule

// File: rtl/fpu_cvt_sched.sv
// Two-port arbiter feeding a shared 2-stage convert pipeline with valid/ready output.
module fpu_cvt_sched
  import fpu_cvt_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             op0,
  input  logic [63:0]      src0,
  input  logic [TAG_W-1:0] tag0,
  output logic             ack0,
  input  logic             req1,
  input  logic             op1,
  input  logic [63:0]      src1,
  input  logic [TAG_W-1:0] tag1,
  output logic             ack1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_port,
  output logic [TAG_W-1:0] out_tag,
  output logic [63:0]      out_data,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             busy
);
  logic             s1_vld_q, s1_vld_d, s1_op_q, s1_op_d, s1_port_q, s1_port_d;
  logic [63:0]      s1_src_q, s1_src_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_vld_q, s2_vld_d, s2_port_q, s2_port_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  cvt_res_t         s2_res_q, s2_res_d, core_res;
  logic             ptr_q, ptr_d;
  logic             s1_take, s2_take, gnt0, gnt1;

  fpu_cvt_core u_core (
    .op  (s1_op_q),
    .src (s1_src_q),
    .res (core_res)
  );

  always_comb begin
    s2_take   = !s2_vld_q || out_ready;
    s1_take   = !s1_vld_q || s2_take;
    gnt0      = s1_take && req0 && ((FIXED_PRIO != 0) || !ptr_q || !req1);
    gnt1      = s1_take && req1 && !gnt0;
    ptr_d     = ptr_q;
    s1_vld_d  = s1_vld_q;
    s1_op_d   = s1_op_q;
    s1_port_d = s1_port_q;
    s1_src_d  = s1_src_q;
    s1_tag_d  = s1_tag_q;
    s2_vld_d  = s2_vld_q;
    s2_port_d = s2_port_q;
    s2_tag_d  = s2_tag_q;
    s2_res_d  = s2_res_q;
    // pointer parks on the port that lost (or did not ask)
    if (gnt0 || gnt1) ptr_d = gnt0;
    if (s1_take) begin
      s1_vld_d = gnt0 || gnt1;
      if (gnt0 || gnt1) begin
        s1_op_d   = gnt0 ? op0  : op1;
        s1_src_d  = gnt0 ? src0 : src1;
        s1_tag_d  = gnt0 ? tag0 : tag1;
        s1_port_d = gnt1;
      end
    end
    if (s2_take) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_res_d  = core_res;
        s2_tag_d  = s1_tag_q;
        s2_port_d = s1_port_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_op_q   <= 1'b0;
      s1_port_q <= 1'b0;
      s1_src_q  <= '0;
      s1_tag_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_port_q <= 1'b0;
      s2_tag_q  <= '0;
      s2_res_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      s1_vld_q  <= s1_vld_d;
      s1_op_q   <= s1_op_d;
      s1_port_q <= s1_port_d;
      s1_src_q  <= s1_src_d;
      s1_tag_q  <= s1_tag_d;
      s2_vld_q  <= s2_vld_d;
      s2_port_q <= s2_port_d;
      s2_tag_q  <= s2_tag_d;
      s2_res_q  <= s2_res_d;
    end
  end

  assign ack0      = gnt0 && !reset;
  assign ack1      = gnt1 && !reset;
  assign out_valid = s2_vld_q;
  assign out_port  = s2_port_q;
  assign out_tag   = s2_tag_q;
  assign out_data  = s2_res_q.data;
  assign out_ovf   = s2_res_q.ovf;
  assign out_unf   = s2_res_q.unf;
  assign busy      = s1_vld_q || s2_vld_q;
endmodule

// File: tb/tb_fpu_cvt_sched.sv
// Directed bench for fpu_cvt_sched: round-robin instance plus a fixed-priority twin.
module tb_fpu_cvt_sched;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req0 = 0, op0 = 0, req1 = 0, op1 = 0, out_ready = 1;
  logic [63:0] src0 = '0, src1 = '0;
  logic [3:0]  tag0 = '0, tag1 = '0;
  logic        ack0, ack1, out_valid, out_port, out_ovf, out_unf, busy;
  logic [3:0]  out_tag;
  logic [63:0] out_data;
  logic        f_ack0, f_ack1, f_valid, f_port, f_ovf, f_unf, f_busy;
  logic [3:0]  f_tag;
  logic [63:0] f_data;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  fpu_cvt_sched #(.FIXED_PRIO(0), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .src0(src0), .tag0(tag0), .ack0(ack0),
    .req1(req1), .op1(op1), .src1(src1), .tag1(tag1), .ack1(ack1),
    .out_valid(out_valid), .out_ready(out_ready), .out_port(out_port),
    .out_tag(out_tag), .out_data(out_data), .out_ovf(out_ovf), .out_unf(out_unf),
    .busy(busy));

  fpu_cvt_sched #(.FIXED_PRIO(1), .TAG_W(4)) dut_fp (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .src0(src0), .tag0(tag0), .ack0(f_ack0),
    .req1(req1), .op1(op1), .src1(src1), .tag1(tag1), .ack1(f_ack1),
    .out_valid(f_valid), .out_ready(out_ready), .out_port(f_port),
    .out_tag(f_tag), .out_data(f_data), .out_ovf(f_ovf), .out_unf(f_unf),
    .busy(f_busy));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; req0 = 0; req1 = 0; out_ready = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; req0 = 0; req1 = 0;
    step(); step();
    checks++;
    if ({out_valid, out_ovf, out_unf, busy, ack0, ack1, out_port} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000000",
                         {out_valid, out_ovf, out_unf, busy, ack0, ack1, out_port});
    end
    checks++;
    if (out_data !== 64'h0) begin
      errors++; $display("FAIL reset_data got %h want 0", out_data);
    end
    checks++;
    if (out_tag !== 4'h0) begin
      errors++; $display("FAIL reset_tag got %h want 0", out_tag);
    end
    reset = 0;
  endtask

  task automatic test_conv(input logic port, input logic op, input logic [63:0] src,
                           input logic [3:0] tag, input logic [63:0] exp_data,
                           input logic exp_ovf, input logic exp_unf, input string name);
    out_ready = 1;
    if (port) begin req1 = 1; op1 = op; src1 = src; tag1 = tag; end
    else      begin req0 = 1; op0 = op; src0 = src; tag0 = tag; end
    #1;
    checks++;
    if ((port ? ack1 : ack0) !== 1'b1 || (port ? ack0 : ack1) !== 1'b0) begin
      errors++; $display("FAIL %s_ack got %b%b want port %0d only", name, ack1, ack0, port);
    end
    step();
    req0 = 0; req1 = 0; #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL %s_lat1 got valid=%b busy=%b want 0 1", name, out_valid, busy);
    end
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s_valid got %b want 1", name, out_valid);
    end
    checks++;
    if (out_data !== exp_data) begin
      errors++; $display("FAIL %s_data got %h want %h", name, out_data, exp_data);
    end
    checks++;
    if (out_ovf !== exp_ovf || out_unf !== exp_unf) begin
      errors++; $display("FAIL %s_flags got ovf=%b unf=%b want %b %b", name, out_ovf, out_unf,
                         exp_ovf, exp_unf);
    end
    checks++;
    if (out_tag !== tag || out_port !== port) begin
      errors++; $display("FAIL %s_id got tag=%h port=%b want %h %b", name, out_tag, out_port,
                         tag, port);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_drain got valid=%b busy=%b want 0 0", name, out_valid, busy);
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    op0 = 0; src0 = 64'h3FF0_0000_0000_0000; tag0 = 4'h3;
    op1 = 1; src1 = 64'h0000_0000_C040_0000; tag1 = 4'h4;
    req0 = 1; req1 = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (ack0 !== (c % 2 == 0) || ack1 !== (c % 2 == 1)) begin
        errors++; $display("FAIL rr_ack%0d got %b%b want %b%b", c, ack1, ack0,
                           c % 2 == 1, c % 2 == 0);
      end
      checks++;
      if (f_ack0 !== 1'b1 || f_ack1 !== 1'b0) begin
        errors++; $display("FAIL fp_ack%0d got %b%b want 01", c, f_ack1, f_ack0);
      end
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_port !== c[0]) begin
          errors++; $display("FAIL rr_port%0d got v=%b p=%b want 1 %b", c, out_valid,
                             out_port, c[0]);
        end
      end
      step();
    end
    req0 = 0; #1;
    checks++;
    if (f_ack1 !== 1'b1 || f_ack0 !== 1'b0) begin
      errors++; $display("FAIL fp_release got %b%b want 10", f_ack1, f_ack0);
    end
    step();
    req1 = 0;
    step(); step(); step();
  endtask

  task automatic test_backpressure();
    int na0, na1;
    logic g0, g1;
    na0 = 0; na1 = 0;
    do_reset();
    out_ready = 0;
    op0 = 0; src0 = 64'h3FF0_0000_0000_0000; tag0 = 4'h1;
    op1 = 1; src1 = 64'h0000_0000_C040_0000; tag1 = 4'h2;
    req0 = 1; req1 = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      g0 = ack0; g1 = ack1;
      if (g0) na0++;
      if (g1) na1++;
      step();
      if (g0) req0 = 0;
      if (g1) req1 = 0;
      if (c >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'h3F80_0000 || out_tag !== 4'h1 ||
            out_port !== 1'b0) begin
          errors++; $display("FAIL bp_hold%0d got v=%b d=%h t=%h p=%b want 1 3f800000 1 0",
                             c, out_valid, out_data, out_tag, out_port);
        end
      end
    end
    checks++;
    if (na0 != 1 || na1 != 1) begin
      errors++; $display("FAIL bp_acks got %0d+%0d want 1+1", na0, na1);
    end
    out_ready = 1; #1;
    checks++;
    if (out_valid !== 1'b1 || out_port !== 1'b0 || out_tag !== 4'h1) begin
      errors++; $display("FAIL bp_first got v=%b p=%b t=%h want 1 0 1", out_valid, out_port,
                         out_tag);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_port !== 1'b1 || out_tag !== 4'h2 ||
        out_data !== 64'hC008_0000_0000_0000) begin
      errors++; $display("FAIL bp_second got v=%b p=%b t=%h d=%h want 1 1 2 c008000000000000",
                         out_valid, out_port, out_tag, out_data);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_empty got v=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    out_ready = 0;
    op0 = 0; src0 = 64'h3FF0_0000_0000_0000; tag0 = 4'h5;
    op1 = 1; src1 = 64'h0000_0000_C040_0000; tag1 = 4'h6;
    req1 = 1; #1;
    step();
    req1 = 0; req0 = 1; #1;
    checks++;
    if (ack0 !== 1'b1) begin
      errors++; $display("FAIL mid_fill got ack0=%b want 1", ack0);
    end
    step();
    req0 = 0; req1 = 1; #1;
    checks++;
    if (ack1 !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_full got ack1=%b busy=%b v=%b want 0 1 1", ack1, busy,
                         out_valid);
    end
    reset = 1;
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || ack1 !== 1'b0 || ack0 !== 1'b0) begin
      errors++; $display("FAIL mid_reset got v=%b busy=%b ack=%b%b want 0 0 00", out_valid,
                         busy, ack1, ack0);
    end
    reset = 0; req0 = 1; #1;
    checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
      errors++; $display("FAIL post_reset_grant got %b%b want 01", ack1, ack0);
    end
    step();
    req0 = 0; req1 = 0; out_ready = 1;
    step(); step(); step();
  endtask

  initial begin
    test_reset();
    test_conv(0, 0, 64'h3FF0_0000_0000_0000, 4'hA, 64'h3F80_0000, 0, 0, "d2s_one");
    test_conv(0, 0, 64'h3FF8_0000_0000_0001, 4'hB, 64'h3FC0_0000, 0, 0, "d2s_trunc");
    test_conv(1, 0, 64'h47F0_0000_0000_0000, 4'h1, 64'h7F80_0000, 0, 0, "d2s_eb255");
    test_conv(0, 0, 64'h4800_0000_0000_0000, 4'h2, 64'h7F80_0000, 1, 0, "d2s_ovf");
    test_conv(1, 0, 64'hC800_0000_0000_0000, 4'h3, 64'hFF80_0000, 1, 0, "d2s_novf");
    test_conv(0, 0, 64'h7FF8_0000_0000_0000, 4'h4, 64'h7F80_0000, 1, 0, "d2s_nan");
    test_conv(1, 0, 64'hB700_0000_0000_0000, 4'h5, 64'h0, 0, 1, "d2s_unf");
    test_conv(1, 1, 64'h0000_0000_C040_0000, 4'h6, 64'hC008_0000_0000_0000, 0, 0, "s2d_norm");
    test_conv(0, 1, 64'h0000_0000_8000_0000, 4'h7, 64'h8000_0000_0000_0000, 0, 0, "s2d_zero");
    test_conv(0, 1, 64'h0000_0000_7F80_0000, 4'h8, 64'h7FF0_0000_0000_0000, 0, 0, "s2d_inf");
    test_arbitration();
    test_backpressure();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end
endmodule
